instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage directly upstream of decode/immediate generation. Holds the PC,
//  issues word fetches to instruction memory over a req/gnt + rvalid protocol, buffers
//  returned words in a small in-order queue, and presents {instr, instr_pc} to decode
//  via valid/ready. Accepts branch/jump redirects from execute and discards stale fetches.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC fetched first after reset release
//  FIFO_DEPTH  2              instruction queue entries (power of 2, >=2); also max in-flight credit
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   asynchronous active-low reset
//  imem_req        out  1   fetch request valid
//  imem_addr       out  32  fetch byte address (word aligned, [1:0]=0)
//  imem_gnt        in   1   request accepted this cycle when imem_req & imem_gnt
//  imem_rvalid     in   1   read data valid; one per accepted request, in order, >=1 cycle later
//  imem_rdata      in   32  fetched instruction word
//  redirect_valid  in   1   one-cycle pulse: flush and restart at redirect_pc
//  redirect_pc     in   32  new PC; bits [1:0] ignored (forced to 0)
//  instr_valid     out  1   decode output valid
//  instr_ready     in   1   decode accepts when instr_valid & instr_ready
//  instr           out  32  instruction word to decode
//  instr_pc        out  32  byte address of instr
// BEHAVIOUR
//  - Reset (async assert, sync release): pc=RESET_PC, imem_req=0, instr_valid=0,
//    instr=32'h0000_0013 (NOP), instr_pc=0, queue empty, outstanding=0, drop_cnt=0, state=BOOT.
//  - FSM: BOOT -> RUN unconditionally one cycle after reset release (first imem_req then).
//    RUN -> DRAIN on redirect_valid while outstanding>0 (after accounting same-cycle rvalid);
//    DRAIN -> RUN when drop_cnt reaches 0; redirect in DRAIN reloads drop_cnt = outstanding.
//  - Credit: imem_req = (state!=BOOT) & (outstanding + count < FIFO_DEPTH). Queue can never overflow.
//  - imem_addr = pc combinationally; pc += 4 on each accepted request (wraps 32'hFFFF_FFFC -> 0).
//  - outstanding: +1 on accept, -1 on imem_rvalid; both same cycle -> unchanged.
//  - Response: if drop_cnt>0, discard word and decrement drop_cnt; else push {rdata, pc of that req}
//    (in-flight PCs kept in a FIFO_DEPTH-deep tag queue alongside the credit counter).
//  - Output from queue head: instr_valid = !empty; pop on instr_valid & instr_ready.
//    rvalid -> instr_valid latency = 1 cycle (registered, no bypass). Push+pop same cycle allowed.
//  - Redirect (highest priority): queue flushed, instr_valid=0 next cycle, pc <= {redirect_pc[31:2],2'b00},
//    drop_cnt <= outstanding + accepted-this-cycle - rvalid-this-cycle; any request granted in the
//    redirect cycle uses the old pc and is dropped. New address requested the cycle after redirect.
//  - Redirect with instr_valid & instr_ready same cycle: pop is taken (decode consumed it), then flush.
//  - imem_gnt without imem_req is ignored; imem_rvalid with outstanding==0 is a protocol error
//    (assertion, data discarded).
//  - Reset mid-operation: all state cleared immediately; late responses after release are not
//    expected (memory reset together).
// STRUCTURE
//  - fetch_pkg: NOP_INSTR constant, fetch_state_e {BOOT,RUN,DRAIN}, RESET_PC default, PC increment 4.
//  - Sub-module fetch_fifo (WIDTH, DEPTH): sync FIFO with push/pop/flush/count/empty/full; instanced
//    twice: instruction queue (64b {pc,instr}) and in-flight PC tag queue (32b).
//  - Top: FSM, pc register, outstanding/drop counters, handshake glue.
// TESTING
//  1. Reset release, gnt=1, rvalid 1 cycle later, ready=1 -> addrs 0,4,8...; instr_pc follows, no gaps.
//  2. ready=0 held -> exactly 2 requests issued, instr_valid=1 with pc 0, imem_req drops to 0;
//     ready=1 -> requests resume at addr 8.
//  3. gnt=0 for 5 cycles -> imem_req held 1, imem_addr stable at same value, no pc advance.
//  4. Two in flight (0,4), redirect_pc=32'h0000_0102 -> responses for 0,4 dropped, next imem_addr=0x100,
//     first instr_pc=0x100.
//  5. Redirect same cycle as rvalid and accept -> drop_cnt correct, no stale instr reaches decode.
//  6. redirect_pc=32'hFFFF_FFFC -> fetches FFFF_FFFC then 0000_0000 (wrap).

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared constants, state encoding and helpers for the instruction fetch stage.
package instr_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO with flush. The head entry is read combinationally,
// so a word pushed on one edge becomes visible at the head on the next cycle.
module instr_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_doPush;
  logic             w_doPop;

  assign o_count  = r_wrPtr - r_rdPtr;
  assign o_empty  = (o_count == '0);
  assign o_full   = (o_count == FULL_CNT);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_rdata  = r_mem[r_rdPtr[AW-1:0]];

  // Flush wins over a simultaneous push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush && !i_flush) begin
      r_mem[r_wrPtr[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order response
// queue to decode, and redirect handling that discards stale in-flight words.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = FIFO_DEPTH[CW:0];
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  fetch_state_e  r_state;
  fetch_state_e  w_stateNext;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_dropCnt;
  logic [CW-1:0] w_dropNext;
  logic [CW-1:0] w_outstanding;
  logic [CW-1:0] w_qCount;
  logic [CW:0]   w_inUse;
  logic [CW-1:0] w_accCnt;
  logic [CW-1:0] w_respCnt;
  logic          w_qEmpty;
  logic          w_qFull;
  logic          w_tagEmpty;
  logic          w_tagFull;
  logic [63:0]   w_qHead;
  logic [31:0]   w_tagHead;
  logic          w_req;
  logic          w_accept;
  logic          w_resp;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;

  // Outstanding requests plus buffered words never exceed the queue depth.
  assign w_inUse   = {1'b0, w_outstanding} + {1'b0, w_qCount};
  assign w_req     = (r_state != BOOT) && (w_inUse < DEPTH_W);
  assign w_accept  = w_req && i_imem_gnt;
  assign w_resp    = i_imem_rvalid && !w_tagEmpty;
  assign w_drop    = w_resp && (r_dropCnt != '0);
  assign w_push    = w_resp && !w_drop;
  assign w_pop     = !w_qEmpty && i_instr_ready;
  assign w_accCnt  = {{(CW-1){1'b0}}, w_accept};
  assign w_respCnt = {{(CW-1){1'b0}}, w_resp};

  assign o_imem_req    = w_req;
  assign o_imem_addr   = r_pc;
  assign o_instr_valid = !w_qEmpty;
  assign o_instr       = w_qEmpty ? NOP_INSTR : w_qHead[31:0];
  assign o_instr_pc    = w_qEmpty ? 32'h0000_0000 : w_qHead[63:32];

  // A redirect turns everything still in flight (including a request granted
  // in the redirect cycle) into words to be discarded.
  always_comb begin
    w_stateNext = r_state;
    w_dropNext  = r_dropCnt;
    if (i_redirect_valid) begin
      w_dropNext = w_outstanding + w_accCnt - w_respCnt;
    end else if (w_drop) begin
      w_dropNext = r_dropCnt - CNT_ONE;
    end
    case (r_state)
      BOOT:    w_stateNext = RUN;
      RUN:     if (i_redirect_valid && (w_dropNext != '0)) w_stateNext = DRAIN;
      DRAIN:   if (w_dropNext == '0) w_stateNext = RUN;
      default: w_stateNext = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= BOOT;
      r_dropCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_dropCnt <= w_dropNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_redirect_valid) begin
      r_pc <= alignWord(i_redirect_pc);
    end else if (w_accept) begin
      r_pc <= r_pc + PC_INCR;
    end
  end

  // Tag queue: one PC per in-flight request; its occupancy is the credit count.
  instr_fetch_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tagQueue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_pop   (w_resp),
    .i_flush (1'b0),
    .i_wdata (r_pc),
    .o_rdata (w_tagHead),
    .o_count (w_outstanding),
    .o_empty (w_tagEmpty),
    .o_full  (w_tagFull)
  );

  instr_fetch_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_instrQueue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect_valid),
    .i_wdata ({w_tagHead, i_imem_rdata}),
    .o_rdata (w_qHead),
    .o_count (w_qCount),
    .o_empty (w_qEmpty),
    .o_full  (w_qFull)
  );

  a_rvalidNeedsOutstanding : assert property (@(posedge clk) disable iff (!rst_n)
    i_imem_rvalid |-> (w_outstanding != '0));

  a_tagNoOverflow : assert property (@(posedge clk) disable iff (!rst_n)
    w_accept |-> !w_tagFull);

  a_queueNoOverflow : assert property (@(posedge clk) disable iff (!rst_n)
    w_push |-> (!w_qFull || w_pop));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch with hand-computed expectations.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expInstr;
    logic [31:0] expPc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt = 1'b0;
  logic        imemRvalid = 1'b0;
  logic [31:0] imemRdata = 32'h0;
  logic        redirValid = 1'b0;
  logic [31:0] redirPc = 32'h0;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic [31:0] instrWord;
  logic [31:0] instrPc;

  int errors = 0;
  int checks = 0;
  vec_t tbl[16];

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .o_imem_req       (imemReq),
    .o_imem_addr      (imemAddr),
    .i_imem_gnt       (imemGnt),
    .i_imem_rvalid    (imemRvalid),
    .i_imem_rdata     (imemRdata),
    .i_redirect_valid (redirValid),
    .i_redirect_pc    (redirPc),
    .o_instr_valid    (instrValid),
    .i_instr_ready    (instrReady),
    .o_instr          (instrWord),
    .o_instr_pc       (instrPc)
  );

  function automatic vec_t mk(logic gnt, logic rv, logic [31:0] rd, logic redir,
                              logic [31:0] rpc, logic rdy, logic eReq, logic [31:0] eAddr,
                              logic eVal, logic [31:0] eInstr, logic [31:0] ePc);
    vec_t v;
    v.gnt = gnt; v.rvalid = rv; v.rdata = rd; v.redir = redir; v.rpc = rpc; v.ready = rdy;
    v.expReq = eReq; v.expAddr = eAddr; v.expValid = eVal; v.expInstr = eInstr; v.expPc = ePc;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    imemGnt    = v.gnt;
    imemRvalid = v.rvalid;
    imemRdata  = v.rdata;
    redirValid = v.redir;
    redirPc    = v.rpc;
    instrReady = v.ready;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    checks++;
    if (imemReq !== v.expReq || imemAddr !== v.expAddr || instrValid !== v.expValid ||
        instrWord !== v.expInstr || instrPc !== v.expPc) begin
      errors++;
      $display("[TB] FAIL %s: req/addr/valid/instr/pc got %b/%h/%b/%h/%h want %b/%h/%b/%h/%h",
               name, imemReq, imemAddr, instrValid, instrWord, instrPc,
               v.expReq, v.expAddr, v.expValid, v.expInstr, v.expPc);
    end
  endtask

  task automatic runVec(input string name, input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput(name, v);
  endtask

  // Asserts reset, checks the cleared outputs, then releases and checks the BOOT cycle.
  task automatic doReset(input string name, input logic ready);
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, NOP, 32'h0));
    #1;
    checkOutput({name, "_reset"}, mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, NOP, 32'h0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, ready, 1'b0, 32'h0, 1'b0, NOP, 32'h0));
    #1;
    checkOutput({name, "_boot"}, mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, ready, 1'b0, 32'h0, 1'b0, NOP, 32'h0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Streaming with 1-cycle memory latency, gnt ignored without req, then gnt stalled.
    tbl[0]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b1, 32'h0,  1'b0, NOP,           32'h0);
    tbl[1]  = mk(1'b1, 1'b1, 32'h1000_0000, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4,  1'b0, NOP,           32'h0);
    tbl[2]  = mk(1'b1, 1'b1, 32'h1000_0004, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8,  1'b1, 32'h1000_0000, 32'h0);
    tbl[3]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h1000_0004, 32'h4);
    tbl[4]  = mk(1'b1, 1'b1, 32'h1000_0008, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC,  1'b0, NOP,           32'h0);
    tbl[5]  = mk(1'b1, 1'b1, 32'h1000_000C, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h1000_0008, 32'h8);
    tbl[6]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h1000_000C, 32'hC);
    for (int i = 7; i < 12; i++) begin
      tbl[i] = mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b0, NOP, 32'h0);
    end
    tbl[12] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b0, NOP,           32'h0);
    tbl[13] = mk(1'b0, 1'b1, 32'h1000_0010, 1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 1'b0, NOP,           32'h0);
    tbl[14] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h1000_0010, 32'h10);
    tbl[15] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 1'b0, NOP,           32'h0);

    doReset("t1", 1'b1);
    for (int i = 0; i < 16; i++) begin
      runVec($sformatf("t1_row%0d", i), tbl[i]);
    end

    // Decode stalled: credit stops requests after two, then resumes at 8.
    doReset("t2", 1'b0);
    runVec("t2_r1", mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, NOP,           32'h0));
    runVec("t2_r2", mk(1'b1, 1'b1, 32'h2000_0000, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, NOP,           32'h0));
    runVec("t2_r3", mk(1'b1, 1'b1, 32'h2000_0004, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8, 1'b1, 32'h2000_0000, 32'h0));
    runVec("t2_r4", mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 32'h8, 1'b1, 32'h2000_0000, 32'h0));
    runVec("t2_r5", mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 32'h8, 1'b1, 32'h2000_0000, 32'h0));
    runVec("t2_r6", mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 1'b1, 32'h2000_0000, 32'h0));
    runVec("t2_r7", mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h2000_0004, 32'h4));
    runVec("t2_r8", mk(1'b0, 1'b1, 32'h2000_0008, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b0, NOP,           32'h0));
    runVec("t2_r9", mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b1, 32'h2000_0008, 32'h8));

    // Redirect with two requests in flight: both responses dropped.
    doReset("t4", 1'b1);
    runVec("t4_s1", mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, NOP,           32'h0));
    runVec("t4_s2", mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b0, NOP,           32'h0));
    runVec("t4_s3", mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h102, 1'b1, 1'b0, 32'h8,   1'b0, NOP,           32'h0));
    runVec("t4_s4", mk(1'b0, 1'b1, 32'hDEAD_0000, 1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 1'b0, NOP,           32'h0));
    runVec("t4_s5", mk(1'b1, 1'b1, 32'hDEAD_0004, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, NOP,           32'h0));
    runVec("t4_s6", mk(1'b0, 1'b1, 32'h3000_0100, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, NOP,           32'h0));
    runVec("t4_s7", mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b1, 32'h3000_0100, 32'h100));
    runVec("t4_s8", mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, NOP,           32'h0));

    // Redirect in the same cycle as a response and an accepted request.
    runVec("t5_0", mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, NOP,           32'h0));
    runVec("t5_1", mk(1'b1, 1'b1, 32'h4000_0104, 1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b0, NOP,           32'h0));
    runVec("t5_2", mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b0, 32'h10C, 1'b1, 32'h4000_0104, 32'h104));
    runVec("t5_3", mk(1'b1, 1'b1, 32'h4000_0108, 1'b1, 32'h200, 1'b1, 1'b1, 32'h10C, 1'b0, NOP,           32'h0));
    runVec("t5_4", mk(1'b1, 1'b1, 32'h4000_010C, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, NOP,           32'h0));
    runVec("t5_5", mk(1'b0, 1'b1, 32'h5000_0200, 1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b0, NOP,           32'h0));
    runVec("t5_6", mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b1, 32'h5000_0200, 32'h200));
    runVec("t5_7", mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b0, NOP,           32'h0));

    // Unaligned redirect to the top word, PC wrap, then redirect while decode pops.
    runVec("t6_0", mk(1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h204,       1'b0, NOP,           32'h0));
    runVec("t6_1", mk(1'b1, 1'b1, 32'hBAD0_0204, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, NOP,           32'h0));
    runVec("t6_2", mk(1'b1, 1'b1, 32'h6000_FFFC, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, NOP,           32'h0));
    runVec("t6_3", mk(1'b0, 1'b1, 32'h6000_0000, 1'b0, 32'h0,         1'b1, 1'b0, 32'h4,         1'b1, 32'h6000_FFFC, 32'hFFFF_FFFC));
    runVec("t6_4", mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h300,       1'b1, 1'b1, 32'h4,         1'b1, 32'h6000_0000, 32'h0));
    runVec("t6_5", mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h300,       1'b0, NOP,           32'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
